// File: rtl/interrupt_controller.sv
// interrupt_controller
//   Collects NMI, ECALL, EBREAK, timer and external interrupt requests into
//   pending flags. It picks one by fixed priority (NMI > ECALL > EBREAK > TMR >
//   INT, lowest external index first) and presents it to the core. Each trap
//   goes through a request / acknowledge / return handshake.
//
//   Optional build macro: INTC_NMI_NEST_EN
//     If defined, an NMI may pre-empt a running non-NMI handler. The interrupted
//     cause is kept in a one-deep stack and restored by the NMI's mret.
//     If undefined, an NMI waits for mret like every other source.
//
// Ports
//   clk        core clock
//   rst        synchronous active-low reset
//   nmi        non-maskable interrupt line, rising-edge sensitive
//   ecall      one-cycle pulse from the decoder when ECALL retires
//   ebreak     one-cycle pulse from the decoder when EBREAK retires
//   tmr_irq    timer interrupt line, rising-edge sensitive
//   ext_irq    external interrupt lines, rising-edge sensitive
//   gie        global enable for the timer and external sources
//   irq_ack    core redirected the PC to the trap address this cycle
//   mret       one-cycle pulse when the trap handler returns
//   interruptF trap request valid
//   interSel   cause: NMI=0, ECALL=1, EBREAK=2, TMR=3, INT=4
//   intNum     external line index, valid when interSel=INT
//   in_service a handler is executing
//   pending    raw pending flags {ext, tmr, ebreak, ecall, nmi}
module interrupt_controller #(
  parameter  int NUM_W   = 1,
  localparam int NUM_EXT = 2 ** NUM_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               nmi,
  input  logic               ecall,
  input  logic               ebreak,
  input  logic               tmr_irq,
  input  logic [NUM_EXT-1:0] ext_irq,
  input  logic               gie,
  input  logic               irq_ack,
  input  logic               mret,
  output logic               interruptF,
  output logic [2:0]         interSel,
  output logic [NUM_W-1:0]   intNum,
  output logic               in_service,
  output logic [NUM_EXT+3:0] pending
);

  localparam int PW = NUM_EXT + 4;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  localparam logic [2:0] SEL_NMI    = 3'd0;
  localparam logic [2:0] SEL_ECALL  = 3'd1;
  localparam logic [2:0] SEL_EBREAK = 3'd2;
  localparam logic [2:0] SEL_TMR    = 3'd3;
  localparam logic [2:0] SEL_INT    = 3'd4;

  logic [1:0]         stateQ;
  logic               nmiQ;
  logic               tmrQ;
  logic [NUM_EXT-1:0] extQ;
  logic [PW-1:0]      pendingQ;
  logic [2:0]         selQ;
  logic [NUM_W-1:0]   numQ;
  logic               inSvcQ;
`ifdef INTC_NMI_NEST_EN
  logic               nestedQ;
  logic [2:0]         savedSel;
  logic [NUM_W-1:0]   savedNum;
`endif

  logic [PW-1:0]      setVec;
  logic [PW-1:0]      clrVec;
  logic [PW-1:0]      eligVec;
  logic [NUM_EXT-1:0] extElig;
  logic [PW-1:0]      pendingNext;
  logic               winValid;
  logic [2:0]         winSel;
  logic [NUM_W-1:0]   winNum;
  int unsigned        causeIdx;

  always_comb begin
    setVec  = {ext_irq & ~extQ, tmr_irq & ~tmrQ, ebreak, ecall, nmi & ~nmiQ};
    eligVec = pendingQ & {{NUM_EXT{gie}}, gie, 3'b111};
    extElig = eligVec[PW-1:4];

    winValid = 1'b0;
    winSel   = SEL_NMI;
    winNum   = '0;
    if (eligVec[0]) begin
      winValid = 1'b1;
      winSel   = SEL_NMI;
    end else if (eligVec[1]) begin
      winValid = 1'b1;
      winSel   = SEL_ECALL;
    end else if (eligVec[2]) begin
      winValid = 1'b1;
      winSel   = SEL_EBREAK;
    end else if (eligVec[3]) begin
      winValid = 1'b1;
      winSel   = SEL_TMR;
    end else begin
      for (int unsigned i = 0; i < NUM_EXT; i++) begin
        if (!winValid && extElig[i]) begin
          winValid = 1'b1;
          winSel   = SEL_INT;
          winNum   = NUM_W'(i);
        end
      end
    end

    // The acknowledge clears the latched cause's flag. A new edge in the same
    // cycle is OR-ed in afterwards, so a set and a clear together leave the flag pending.
    causeIdx = (selQ == SEL_INT) ? 32'd4 + 32'(numQ) : 32'(selQ);
    clrVec   = (stateQ == REQ && irq_ack) ? (PW'(1) << causeIdx) : '0;
    pendingNext = (pendingQ & ~clrVec) | setVec;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stateQ   <= IDLE;
      nmiQ     <= 1'b0;
      tmrQ     <= 1'b0;
      extQ     <= '0;
      pendingQ <= '0;
      selQ     <= SEL_NMI;
      numQ     <= '0;
      inSvcQ   <= 1'b0;
`ifdef INTC_NMI_NEST_EN
      nestedQ  <= 1'b0;
      savedSel <= SEL_NMI;
      savedNum <= '0;
`endif
    end else begin
      nmiQ     <= nmi;
      tmrQ     <= tmr_irq;
      extQ     <= ext_irq;
      pendingQ <= pendingNext;
      case (stateQ)
        IDLE: begin
          if (winValid) begin
            selQ   <= winSel;
            numQ   <= winNum;
            stateQ <= REQ;
          end
        end
        REQ: begin
          // The cause stays frozen here, so a later higher-priority flag waits.
          if (irq_ack) begin
            stateQ <= SERVICE;
            inSvcQ <= 1'b1;
          end
        end
        SERVICE: begin
          if (mret) begin
`ifdef INTC_NMI_NEST_EN
            if (nestedQ) begin
              selQ    <= savedSel;
              numQ    <= savedNum;
              nestedQ <= 1'b0;
            end else begin
              stateQ <= IDLE;
              inSvcQ <= 1'b0;
            end
`else
            stateQ <= IDLE;
            inSvcQ <= 1'b0;
`endif
          end
`ifdef INTC_NMI_NEST_EN
          // A returning handler takes precedence over pre-emption in the same cycle.
          else if (pendingQ[0] && selQ != SEL_NMI && !nestedQ) begin
            savedSel <= selQ;
            savedNum <= numQ;
            selQ     <= SEL_NMI;
            numQ     <= '0;
            nestedQ  <= 1'b1;
            stateQ   <= REQ;
          end
`endif
        end
        default: stateQ <= IDLE;
      endcase
    end
  end

  assign interruptF = (stateQ == REQ);
  assign interSel   = selQ;
  assign intNum     = numQ;
  assign in_service = inSvcQ;
  assign pending    = pendingQ;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller
//   Directed bench for interrupt_controller with NUM_W=1, which gives two
//   external lines and a 6-bit pending vector {ext[1:0], tmr, ebreak, ecall, nmi}.
//   Inputs change 1 ns after a rising edge, and outputs are sampled at that time.
module tb_interrupt_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       nmi;
  logic       ecall;
  logic       ebreak;
  logic       tmr_irq;
  logic [1:0] ext_irq;
  logic       gie;
  logic       irq_ack;
  logic       mret;
  logic       interruptF;
  logic [2:0] interSel;
  logic [0:0] intNum;
  logic       in_service;
  logic [5:0] pending;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  interrupt_controller #(.NUM_W(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .nmi        (nmi),
    .ecall      (ecall),
    .ebreak     (ebreak),
    .tmr_irq    (tmr_irq),
    .ext_irq    (ext_irq),
    .gie        (gie),
    .irq_ack    (irq_ack),
    .mret       (mret),
    .interruptF (interruptF),
    .interSel   (interSel),
    .intNum     (intNum),
    .in_service (in_service),
    .pending    (pending)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b0; nmi = 1'b0; ecall = 1'b0; ebreak = 1'b0; tmr_irq = 1'b0;
    ext_irq = 2'b00; gie = 1'b0; irq_ack = 1'b0; mret = 1'b0;
    #1;
    step(); step();
    check("rst_intF", 32'(interruptF), 32'd0);
    check("rst_sel", 32'(interSel), 32'd0);
    check("rst_num", 32'(intNum), 32'd0);
    check("rst_pend", 32'(pending), 32'd0);
    check("rst_svc", 32'(in_service), 32'd0);
    rst = 1'b1;
    step();

    // Priority: ECALL beats external line 1.
    ecall = 1'b1; ext_irq = 2'b10; gie = 1'b1;
    step();
    ecall = 1'b0;
    check("pri_pend0", 32'(pending), 32'b100010);
    check("pri_intF0", 32'(interruptF), 32'd0);
    step();
    check("pri_intF1", 32'(interruptF), 32'd1);
    check("pri_sel1", 32'(interSel), 32'd1);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("pri_ack_intF", 32'(interruptF), 32'd0);
    check("pri_ack_svc", 32'(in_service), 32'd1);
    check("pri_ack_pend", 32'(pending), 32'b100000);
    step();
    check("pri_svc_noreq", 32'(interruptF), 32'd0);
    mret = 1'b1;
    step();
    mret = 1'b0;
    check("pri_mret_svc", 32'(in_service), 32'd0);
    check("pri_mret_gap", 32'(interruptF), 32'd0);
    step();
    check("pri_int_intF", 32'(interruptF), 32'd1);
    check("pri_int_sel", 32'(interSel), 32'd4);
    check("pri_int_num", 32'(intNum), 32'd1);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("pri_int_clr", 32'(pending), 32'd0);
    mret = 1'b1;
    step();
    mret = 1'b0;
    step();
    check("level_noretrig", 32'(interruptF), 32'd0);
    check("level_pend", 32'(pending), 32'd0);
    ext_irq = 2'b00;

    // Masking: the timer stays pending while gie is low.
    gie = 1'b0; tmr_irq = 1'b1;
    step(); step();
    check("mask_intF", 32'(interruptF), 32'd0);
    check("mask_pend", 32'(pending), 32'b001000);
    step();
    check("mask_intF2", 32'(interruptF), 32'd0);
    gie = 1'b1;
    step();
    check("unmask_intF", 32'(interruptF), 32'd1);
    check("unmask_sel", 32'(interSel), 32'd3);

    // Stable request: an NMI arriving in REQ does not change the cause.
    nmi = 1'b1;
    gie = 1'b0;
    step();
    check("stable_sel", 32'(interSel), 32'd3);
    check("stable_intF", 32'(interruptF), 32'd1);
    check("stable_pend", 32'(pending), 32'b001001);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("stable_ack_pend", 32'(pending), 32'b000001);
    check("stable_ack_svc", 32'(in_service), 32'd1);
    mret = 1'b1;
    step();
    mret = 1'b0;
    step();
    check("nmi_next_intF", 32'(interruptF), 32'd1);
    check("nmi_next_sel", 32'(interSel), 32'd0);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    mret = 1'b1;
    step();
    mret = 1'b0;
    nmi = 1'b0; tmr_irq = 1'b0; gie = 1'b1;
    check("nmi_done_pend", 32'(pending), 32'd0);

    // A set and a clear of the same flag in one cycle: the set wins.
    ext_irq = 2'b01;
    step();
    ext_irq = 2'b00;
    step();
    check("coll_sel", 32'(interSel), 32'd4);
    check("coll_num", 32'(intNum), 32'd0);
    ext_irq = 2'b01; irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("coll_pend", 32'(pending), 32'b010000);
    check("coll_svc", 32'(in_service), 32'd1);
    mret = 1'b1;
    step();
    mret = 1'b0;
    step();
    check("coll_rereq", 32'(interruptF), 32'd1);
    check("coll_resel", 32'(interSel), 32'd4);
    check("coll_renum", 32'(intNum), 32'd0);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    mret = 1'b1;
    step();
    mret = 1'b0;
    ext_irq = 2'b00;
    check("coll_done_pend", 32'(pending), 32'd0);

    // irq_ack in IDLE is ignored.
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("stray_ack_svc", 32'(in_service), 32'd0);
    check("stray_ack_intF", 32'(interruptF), 32'd0);

    // A reset during a handler abandons it.
    ecall = 1'b1;
    step();
    ecall = 1'b0;
    step();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("midrst_pre_svc", 32'(in_service), 32'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("midrst_svc", 32'(in_service), 32'd0);
    check("midrst_intF", 32'(interruptF), 32'd0);
    check("midrst_sel", 32'(interSel), 32'd0);
    check("midrst_pend", 32'(pending), 32'd0);
    step();

`ifdef INTC_NMI_NEST_EN
    // An NMI pre-empts an EBREAK handler, and its mret resumes the EBREAK handler.
    ebreak = 1'b1;
    step();
    ebreak = 1'b0;
    step();
    check("nest_eb_sel", 32'(interSel), 32'd2);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    nmi = 1'b1;
    step();
    step();
    check("nest_intF", 32'(interruptF), 32'd1);
    check("nest_sel", 32'(interSel), 32'd0);
    check("nest_svc", 32'(in_service), 32'd1);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("nest_ack_pend", 32'(pending), 32'd0);
    mret = 1'b1;
    step();
    mret = 1'b0;
    check("nest_restore_sel", 32'(interSel), 32'd2);
    check("nest_restore_svc", 32'(in_service), 32'd1);
    check("nest_restore_intF", 32'(interruptF), 32'd0);
    mret = 1'b1;
    step();
    mret = 1'b0;
    nmi = 1'b0;
    check("nest_idle_svc", 32'(in_service), 32'd0);
    step();
    check("nest_idle_intF", 32'(interruptF), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
